// File: rtl/gate_stim_checker.sv
// Sweeps a two-input gate under test through 00,01,10,11 and checks y against the selected truth table.
// Latency 4*HOLD_CYCLES+1 cycles from accepted start to done; start is ignored (not queued) while a sweep runs.
module gate_stim_checker #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [2:0] op_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_cnt_o,
    output logic [3:0] fail_vec_o
);

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("gate_stim_checker: HOLD_CYCLES must be at least 1");
        end
    endgenerate

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_DRIVE      = 2'd1;
    localparam logic [1:0] ST_CHECK_DONE = 2'd2;
    localparam logic [1:0] ST_REJECT     = 2'd3;

    localparam logic [2:0] OP_MAX_LEGAL  = 3'd5;
    localparam logic [2:0] ERR_REJECTED  = 3'd7;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    vec_q, vec_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [2:0]    err_q, err_d;
    logic [3:0]    fail_q, fail_d;
    logic          exp_y;

    // vec_q drives the gate directly, so it is forced to 00 whenever no vector is applied.
    always_comb begin
        exp_y = 1'b0;
        case (op_q)
            3'd0: exp_y = vec_q[1] & vec_q[0];
            3'd1: exp_y = vec_q[1] | vec_q[0];
            3'd2: exp_y = ~(vec_q[1] & vec_q[0]);
            3'd3: exp_y = ~(vec_q[1] | vec_q[0]);
            3'd4: exp_y = vec_q[1] ^ vec_q[0];
            3'd5: exp_y = ~(vec_q[1] ^ vec_q[0]);
            default: exp_y = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (op_i <= OP_MAX_LEGAL) begin
                        state_d = ST_DRIVE;
                        op_d    = op_i;
                        vec_d   = 2'd0;
                        hold_d  = '0;
                        busy_d  = 1'b1;
                        pass_d  = 1'b0;
                        err_d   = 3'd0;
                        fail_d  = 4'd0;
                    end else begin
                        state_d = ST_REJECT;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        err_d   = ERR_REJECTED;
                        fail_d  = 4'd0;
                    end
                end
            end

            ST_DRIVE: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (y_i != exp_y) begin
                        err_d         = err_q + 3'd1;
                        fail_d[vec_q] = 1'b1;
                    end
                    if (vec_q == 2'd3) begin
                        state_d = ST_CHECK_DONE;
                        vec_d   = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end
            end

            ST_CHECK_DONE: state_d = ST_IDLE;
            ST_REJECT:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            vec_q   <= 2'd0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a_o        = vec_q[1];
    assign b_o        = vec_q[0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_q;
    assign fail_vec_o = fail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: table of sweeps against model gates, scoreboard checked on each done pulse.
module tb_gate_stim_checker;

    localparam int H = 10;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [2:0] op_i;
    logic       y_i;
    logic       a_o;
    logic       b_o;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [2:0] err_cnt_o;
    logic [3:0] fail_vec_o;

    // 0 ideal OR, 1 tied high, 2 tied low, 3 ideal AND, 4 ideal XOR
    logic [2:0] ymode;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fail;
    } res_t;

    typedef struct {
        logic [2:0] op;
        logic [2:0] ymode;
        res_t       exp;
    } vec_t;

    res_t sb[$];
    vec_t tbl[6];
    int   checks;
    int   errors;
    int   done_seen;

    gate_stim_checker #(.HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .y_i        (y_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .err_cnt_o  (err_cnt_o),
        .fail_vec_o (fail_vec_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y_i = 1'b0;
        case (ymode)
            3'd0: y_i = a_o | b_o;
            3'd1: y_i = 1'b1;
            3'd2: y_i = 1'b0;
            3'd3: y_i = a_o & b_o;
            3'd4: y_i = a_o ^ b_o;
            default: y_i = 1'b0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and let the scoreboard consume any done pulse.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (done_o) begin
            done_seen++;
            chk("sb_expected_done", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_pass", int'(pass_o), int'(e.pass));
                chk("sb_err_cnt", int'(err_cnt_o), int'(e.err));
                chk("sb_fail_vec", int'(fail_vec_o), int'(e.fail));
            end
        end
    endtask

    task automatic run_sweep(input vec_t t, input bit disturb);
        int v;
        tick();
        op_i    = t.op;
        ymode   = t.ymode;
        start_i = 1'b1;
        sb.push_back(t.exp);
        for (int n = 1; n <= 4 * H + 1; n++) begin
            tick();
            if (n == 1) start_i = 1'b0;
            if (disturb && n == 15) begin
                start_i = 1'b1;
                op_i    = 3'd5;
            end
            if (disturb && n == 16) start_i = 1'b0;
            if (n <= 4 * H) begin
                v = (n - 1) / H;
                if ((n - 1) % H == 0 || (n - 1) % H == H - 1) begin
                    chk("vec_ab", int'({a_o, b_o}), v);
                    chk("busy_in_drive", int'(busy_o), 1);
                    chk("no_early_done", int'(done_o), 0);
                end
            end else begin
                chk("done_latency", int'(done_o), 1);
                chk("busy_at_done", int'(busy_o), 0);
                chk("ab_at_done", int'({a_o, b_o}), 0);
            end
        end
        tick();
        tick();
        chk("stable_pass", int'(pass_o), int'(t.exp.pass));
        chk("stable_err_cnt", int'(err_cnt_o), int'(t.exp.err));
        chk("stable_fail_vec", int'(fail_vec_o), int'(t.exp.fail));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        op_i      = 3'd0;
        ymode     = 3'd0;

        tbl[0] = '{op: 3'd1, ymode: 3'd0, exp: '{pass: 1'b1, err: 3'd0, fail: 4'b0000}};
        tbl[1] = '{op: 3'd0, ymode: 3'd0, exp: '{pass: 1'b0, err: 3'd2, fail: 4'b0110}};
        tbl[2] = '{op: 3'd4, ymode: 3'd1, exp: '{pass: 1'b0, err: 3'd2, fail: 4'b1001}};
        tbl[3] = '{op: 3'd2, ymode: 3'd2, exp: '{pass: 1'b0, err: 3'd3, fail: 4'b0111}};
        tbl[4] = '{op: 3'd3, ymode: 3'd3, exp: '{pass: 1'b0, err: 3'd2, fail: 4'b1001}};
        tbl[5] = '{op: 3'd5, ymode: 3'd4, exp: '{pass: 1'b0, err: 3'd4, fail: 4'b1111}};

        #2;
        chk("rst_ab", int'({a_o, b_o}), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_pass", int'(pass_o), 0);
        chk("rst_err_cnt", int'(err_cnt_o), 0);
        chk("rst_fail_vec", int'(fail_vec_o), 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_sweep(tbl[i], 1'b0);

        // Illegal op: one-cycle reject, never busy, gate inputs untouched.
        tick();
        op_i    = 3'd6;
        start_i = 1'b1;
        sb.push_back('{pass: 1'b0, err: 3'd7, fail: 4'b0000});
        tick();
        start_i = 1'b0;
        chk("reject_done", int'(done_o), 1);
        chk("reject_busy", int'(busy_o), 0);
        chk("reject_ab", int'({a_o, b_o}), 0);
        tick();
        chk("reject_done_once", int'(done_o), 0);
        chk("reject_err_hold", int'(err_cnt_o), 7);
        chk("reject_busy_after", int'(busy_o), 0);

        // Start and op change mid-sweep must not affect the latched OR sweep.
        d0 = done_seen;
        run_sweep(tbl[0], 1'b1);
        for (int n = 0; n < 4 * H + 5; n++) tick();
        chk("disturb_done_once", done_seen - d0, 1);

        // Async reset in the middle of vector 10.
        tick();
        op_i    = 3'd0;
        ymode   = 3'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int n = 0; n < 2 * H + 3; n++) tick();
        chk("pre_reset_ab", int'({a_o, b_o}), 2);
        chk("pre_reset_err", int'(err_cnt_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ab", int'({a_o, b_o}), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_err_cnt", int'(err_cnt_o), 0);
        chk("arst_fail_vec", int'(fail_vec_o), 0);
        chk("arst_done", int'(done_o), 0);
        sb.delete();
        d0 = done_seen;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4 * H + 5; n++) tick();
        chk("no_done_after_reset", done_seen - d0, 0);
        run_sweep(tbl[0], 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_stim_checker.md
# gate_stim_checker

Synthesizable stimulus-and-check stage for the two-input logic gates in the lab (AND, OR, NAND, NOR, XOR, XNOR). It sits directly upstream and downstream of a gate under test. It drives the gate's `a`/`b` inputs through all four input combinations, samples the gate's `y` output after each settle interval, and compares it against the expected truth table for the selected gate. It then reports pass/fail, a mismatch count, and a per-vector failure mask.

## Interface
- `HOLD_CYCLES`, default 10: cycles each input vector is held before `y` is sampled. Legal values are ≥1. A value of 0 is an elaboration error.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `op`  in  3  gate select, latched on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6–7 invalid
- `y`  in  1  output of gate under test
- `a`  out  1  gate input a (MSB of vector index)
- `b`  out  1  gate input b (LSB of vector index)
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle completion pulse
- `pass`  out  1  1 when last sweep had zero mismatches. Valid from `done` until next accepted start.
- `err_cnt`  out  3  mismatches in last sweep, 0–4. The value 7 means the op was rejected.
- `fail_vec`  out  4  bit v set when vector v = {a,b} mismatched

## Operation
- The state machine has four states: IDLE, DRIVE, CHECK_DONE, REJECT.
- **Reset values** (asynchronous on `rst_n`=0):
  - State is IDLE.
  - `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0.
  - Vector index and hold counter are 0.
- **IDLE, start with legal op:**
  - On `start`=1 with `op`≤5: latch `op`, clear `err_cnt` and `fail_vec`, clear `pass`, set vector index v=0 and hold counter 0. Go to DRIVE.
- **IDLE, start with illegal op:**
  - On `start`=1 with `op`≥6: go to REJECT. `a`/`b` stay 0.
- **DRIVE:**
  - `{a,b}` = v and `busy`=1.
  - The hold counter increments each cycle.
  - On the edge ending hold cycle HOLD_CYCLES-1, sample `y` and compare it to expected(op, a, b):
    - On mismatch, `err_cnt`+1 and `fail_vec[v]`=1.
    - If v<3: v+1, hold counter returns to 0, stay in DRIVE.
    - If v=3: go to CHECK_DONE.
- **CHECK_DONE** (one cycle):
  - `done`=1, `busy`=0, `pass` = (`err_cnt`==0).
  - `{a,b}` returns to 00.
  - Next state is IDLE.
- **REJECT** (one cycle):
  - `done`=1, `busy`=0, `pass`=0, `err_cnt`=7, `fail_vec`=0.
  - Next state is IDLE.
- **Start while busy:** `start` asserted in DRIVE, CHECK_DONE or REJECT is ignored; it is not queued.
- **Held start:** `start` held high continuously restarts a sweep on the first IDLE cycle after each `done`.
- **Stable results:** `pass`, `err_cnt` and `fail_vec` hold their values in IDLE until the next accepted start.
- **Reset mid-sweep:** outputs return to reset values immediately. No `done` pulse is produced and no partial results are retained.
- **`op` changes:** changes to `op` during a sweep have no effect, because the latched copy is used.
- **`err_cnt` range:** `err_cnt` never exceeds 4 on a legal sweep and never wraps.

## Timing
- **Latency:** with start accepted at edge k:
  - DRIVE begins in the cycle after edge k, with `a`/`b` already valid in that cycle.
  - Vector v is driven in cycles k+1+v·HOLD_CYCLES through k+(v+1)·HOLD_CYCLES.
  - `done` is high in cycle k+4·HOLD_CYCLES+1.
  - Total latency from start to `done` is 4·HOLD_CYCLES+1 cycles.
- **Sampling point:** `y` is sampled at the last edge of each vector's hold window. This gives HOLD_CYCLES-1 full cycles of settle time for combinational `y`; HOLD_CYCLES=1 means `y` is sampled one edge after the vector is applied.
- **Illegal op:** `done` is high in cycle k+1.
- **Outputs:** all outputs are registered, with no combinational path from `y` or `start` to any output.
- **Back-to-back sweeps:** minimum spacing between two accepted starts is 4·HOLD_CYCLES+2 cycles.

## Test plan
- Reset, then `op`=1, `y` driven by an ideal OR of `a`/`b`, HOLD_CYCLES=10 pulse start → `a`/`b` step 00,01,10,11 at 10-cycle intervals; `done` in cycle 41 after start; `pass`=1, `err_cnt`=0, `fail_vec`=0000.
- `op`=0 (AND) with `y` from an ideal OR → mismatches at vectors 01 and 10; `pass`=0, `err_cnt`=2, `fail_vec`=0110.
- `op`=4 (XOR) with `y` tied to 1 → `err_cnt`=2, `fail_vec`=1001; repeat for `op`=2 (NAND) with `y` tied to 0 → `err_cnt`=3, `fail_vec`=0111.
- `op`=6 start → `done` next cycle, `pass`=0, `err_cnt`=7, `busy` never high, `a`=`b`=0.
- Pulse start again during DRIVE, and change `op` to 5 mid-sweep → second start is ignored and results match the originally latched op; `done` pulses exactly once.
- Assert `rst_n`=0 during vector 10 → `a`,`b`,`busy`,`err_cnt`,`fail_vec` go to 0 asynchronously and no `done` pulse follows. A subsequent start runs a full clean sweep.
